// File: rtl/lsu_ctrl_if.sv
// Bundle of the load/store unit's CPU request/response handshake and its data-memory bus.
// The unit is the master (memory initiator, CPU responder); the environment is the slave.
interface lsu_ctrl_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: byte/half/word accesses to a single-port word memory, sub-word stores by read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests respond at once with resp_err instead of force-aligning.
module lsu_ctrl #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  state_t                r_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;

  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [31:0]           r_resp_rdata;
  logic                  r_resp_err;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;

  logic                  w_accept;
  logic                  w_misaligned;

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   extend_load = {{24{~uns & b[7]}}, b};
      2'b01:   extend_load = {{16{~uns & h[15]}}, h};
      default: extend_load = word;
    endcase
  endfunction

  // Only byte and half stores reach the merge, so anything other than byte is a half.
  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] lane, input logic [1:0] size);
    merge_store = word;
    if (size == 2'b00) merge_store[{lane, 3'b000} +: 8] = wdata[7:0];
    else               merge_store[{lane[1], 4'b0000} +: 16] = wdata[15:0];
  endfunction

  assign w_accept = bus.req_valid & r_req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misaligned = (bus.req_size == 2'b01) ? bus.req_addr[0] :
                        (bus.req_size[1] ? (bus.req_addr[1:0] != 2'b00) : 1'b0);
`else
  assign w_misaligned = 1'b0;
`endif

  // Every bus-visible output is a register updated alongside the state, so nothing toggles combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we         <= bus.req_we;
            r_size       <= bus.req_size;
            r_unsigned   <= bus.req_unsigned;
            r_addr       <= bus.req_addr[ADDR_WIDTH+1:0];
            r_wdata      <= bus.req_wdata;
            r_req_ready  <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_addr   <= bus.req_addr[ADDR_WIDTH+1:2];
            if (w_misaligned) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (!bus.req_we) begin
              r_state    <= LOAD;
              r_mem_read <= 1'b1;
            end else if (bus.req_size[1]) begin
              r_state     <= STORE;
              r_mem_write <= 1'b1;
              r_mem_wdata <= bus.req_wdata;
            end else begin
              r_state    <= RMW_RD;
              r_mem_read <= 1'b1;
            end
          end
        end
        LOAD: begin
          r_mem_read   <= 1'b0;
          r_resp_rdata <= r_we ? 32'h0 : extend_load(bus.mem_rdata, r_addr[1:0], r_size, r_unsigned);
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        STORE: begin
          r_mem_write  <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RMW_RD: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b1;
          r_mem_wdata <= merge_store(bus.mem_rdata, r_wdata, r_addr[1:0], r_size);
          r_state     <= RMW_WR;
        end
        RMW_WR: begin
          r_mem_write  <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed cases plus random traffic against a byte-addressed reference memory.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu_ctrl;

  localparam int ADDR_WIDTH = 11;
  localparam int MEM_WORDS  = 1 << ADDR_WIDTH;
  localparam int MEM_BYTES  = MEM_WORDS * 4;

  logic clk = 1'b0;
  logic rst_n;

  int testsRun    = 0;
  int failCount   = 0;
  int writeCycles = 0;
  int readCycles  = 0;
  int bothCycles  = 0;
  logic [ADDR_WIDTH-1:0] lastWrAddr;
  logic [31:0]           lastWrData;

  logic [31:0] memArr   [MEM_WORDS];
  logic [7:0]  refBytes [MEM_BYTES];

  lsu_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  lsu_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Data memory seen by the unit: combinational read, write on the rising edge.
  assign bus.mem_rdata = bus.mem_read ? memArr[bus.mem_addr] : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_write) memArr[bus.mem_addr] <= bus.mem_wdata;
  end

  always @(negedge clk) begin
    if (bus.mem_write) begin
      writeCycles++;
      lastWrAddr = bus.mem_addr;
      lastWrData = bus.mem_wdata;
    end
    if (bus.mem_read) readCycles++;
    if (bus.mem_read && bus.mem_write) bothCycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: little-endian byte memory, aligned to the access size, with arithmetic sign extension.
  task automatic refAccess(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] expRdata, output logic expErr, output int expLat);
    int n;
    int base;
    logic [63:0] v;
    n = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
    base = int'(addr[ADDR_WIDTH+1:0]);
    base = base - (base % n);
    expErr   = 1'b0;
    expRdata = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((int'(addr[1:0]) % n) != 0) begin
      expErr = 1'b1;
      expLat = 1;
      return;
    end
`endif
    if (we) begin
      for (int k = 0; k < n; k++) refBytes[base + k] = wdata[8*k +: 8];
      expLat = (n == 4) ? 2 : 3;
    end else begin
      v = 64'h0;
      for (int k = 0; k < n; k++) v = v | (64'(refBytes[base + k]) << (8 * k));
      if (!uns && v[8*n-1]) v = v - (64'd1 << (8 * n));
      expRdata = v[31:0];
      expLat   = 2;
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat);
    int waitCnt;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    bus.resp_ready   = 1'b1;
    waitCnt = 0;
    while (!bus.req_ready && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    @(posedge clk); #1;
  endtask

  task automatic doTxn(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] expRdata, gotRdata;
    logic        expErr, gotErr;
    int          expLat, gotLat, rd0, wr0, expRd, expWr;
    refAccess(we, size, uns, addr, wdata, expRdata, expErr, expLat);
    rd0 = readCycles;
    wr0 = writeCycles;
    applyStimulus(we, size, uns, addr, wdata, gotRdata, gotErr, gotLat);
    expRd = (expErr || (we && size[1])) ? 0 : 1;
    expWr = (!expErr && we) ? 1 : 0;
    checkOutput({tag, ".rdata"}, gotRdata, expRdata);
    checkOutput({tag, ".err"}, 32'(gotErr), 32'(expErr));
    checkOutput({tag, ".latency"}, 32'(gotLat), 32'(expLat));
    checkOutput({tag, ".readCycles"}, 32'(readCycles - rd0), 32'(expRd));
    checkOutput({tag, ".writeCycles"}, 32'(writeCycles - wr0), 32'(expWr));
    checkOutput({tag, ".reqReadyBack"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int waitCnt;
    int rd0;
    int wr0;
    logic [31:0] rndAddr;

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.resp_ready   = 1'b0;
    for (int w = 0; w < MEM_WORDS; w++) begin
      memArr[w] = $urandom;
      for (int k = 0; k < 4; k++) refBytes[4*w + k] = memArr[w][8*k +: 8];
    end

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.reqReady", 32'(bus.req_ready), 32'd1);
    checkOutput("reset.respValid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset.respErr", 32'(bus.resp_err), 32'd0);
    checkOutput("reset.memRead", 32'(bus.mem_read), 32'd0);
    checkOutput("reset.memWrite", 32'(bus.mem_write), 32'd0);
    checkOutput("reset.respRdata", bus.resp_rdata, 32'h0);
    checkOutput("reset.memAddr", 32'(bus.mem_addr), 32'h0);
    checkOutput("reset.memWdata", bus.mem_wdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    doTxn("storeWord", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checkOutput("storeWord.memAddr", 32'(lastWrAddr), 32'd4);
    checkOutput("storeWord.memWdata", lastWrData, 32'hDEADBEEF);
    doTxn("loadWord", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    doTxn("setWord4", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    doTxn("storeByte", 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
    checkOutput("storeByte.memAddr", 32'(lastWrAddr), 32'd4);
    checkOutput("storeByte.memWdata", lastWrData, 32'h11AA3344);

    doTxn("setWord8", 1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01);
    doTxn("ldByteS3", 1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
    doTxn("ldByteU3", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
    doTxn("ldHalfS2", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    doTxn("ldByteS0", 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    doTxn("ldHalfU0", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    doTxn("storeHalf", 1'b1, 2'b01, 1'b0, 32'h26, 32'hCAFE1234);
    doTxn("ldAfterHalf", 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);

    // Response backpressure: load word 8 and stall the response.
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h20;
    bus.req_valid    = 1'b1;
    bus.resp_ready   = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    waitCnt = 0;
    while (!bus.resp_valid && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    rd0 = readCycles;
    wr0 = writeCycles;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("stall.respValid", 32'(bus.resp_valid), 32'd1);
      checkOutput("stall.respRdata", bus.resp_rdata, 32'h80FF7F01);
      checkOutput("stall.reqReady", 32'(bus.req_ready), 32'd0);
    end
    checkOutput("stall.noStrobes", 32'((readCycles - rd0) + (writeCycles - wr0)), 32'd0);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release.respValid", 32'(bus.resp_valid), 32'd0);
    checkOutput("release.reqReady", 32'(bus.req_ready), 32'd1);

    doTxn("misWord", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    doTxn("misHalf", 1'b0, 2'b01, 1'b1, 32'h21, 32'h0);
    doTxn("misStore", 1'b1, 2'b10, 1'b0, 32'h31, 32'h01020304);
    doTxn("wrapLoad", 1'b0, 2'b10, 1'b0, 32'hFFFF_E010, 32'h0);

    // Reset asserted between clock edges while the RMW write strobe is up.
    doTxn("setWord16", 1'b1, 2'b10, 1'b0, 32'h40, 32'h55667788);
    bus.req_we       = 1'b1;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h41;
    bus.req_wdata    = 32'h00000099;
    bus.req_valid    = 1'b1;
    bus.resp_ready   = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    waitCnt = 0;
    while (!bus.mem_write && waitCnt < 10) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("rstRmw.reachedWrite", 32'(bus.mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstRmw.memWrite", 32'(bus.mem_write), 32'd0);
    checkOutput("rstRmw.memRead", 32'(bus.mem_read), 32'd0);
    checkOutput("rstRmw.respValid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rstRmw.reqReady", 32'(bus.req_ready), 32'd1);
    checkOutput("rstRmw.memWdata", bus.mem_wdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    doTxn("afterRst", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);

    for (int i = 0; i < 300; i++) begin
      rndAddr = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      doTxn("random", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            rndAddr, $urandom);
    end

    checkOutput("noReadWriteOverlap", 32'(bothCycles), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
